// File: rtl/ram64_reorder_ctrl_pkg.sv
// Shared types for the RAM64 ping-pong reorder sequencer.
// Frame length and state encoding live here so top and bench agree.
package ram64_reorder_ctrl_pkg;

  localparam int LOGN_C = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_STREAM = 2'd3
  } state_e;

endpackage

// File: rtl/ram64_reorder_ctrl_addr_bitrev.sv
// Combinational bit reversal of the read counter for natural-order output.
// Compiled only when FFT_BITREV_EN is defined; otherwise the read address is the counter itself.
`ifdef FFT_BITREV_EN
module ram64_reorder_ctrl_addr_bitrev
  import ram64_reorder_ctrl_pkg::*;
(
  input  logic [LOGN_C-1:0] addr_in,
  output logic [LOGN_C-1:0] addr_out
);

  for (genvar gi = 0; gi < LOGN_C; gi++) begin : g_rev
    assign addr_out[gi] = addr_in[LOGN_C-1-gi];
  end

endmodule
`endif

// File: rtl/ram64_reorder_ctrl.sv
// Ping-pong sequencer for two 64-word RAM banks: writes one bank while reading the other.
// Define FFT_BITREV_EN to read each bank in bit-reversed address order.
module ram64_reorder_ctrl
  import ram64_reorder_ctrl_pkg::*;
#(
  parameter int LOGN = 6
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            ED,
  input  logic            START,
  output logic [LOGN-1:0] ADDR0,
  output logic            WE0,
  output logic [LOGN-1:0] ADDR1,
  output logic            WE1,
  output logic            OSEL,
  output logic            OVLD,
  output logic            OFIRST,
  output logic            FRM_ERR
);

  if (LOGN != LOGN_C) begin : g_bad_logn
    $error("ram64_reorder_ctrl: only LOGN=6 is supported");
  end

  localparam logic [LOGN-1:0] CNT_ONE = LOGN'(1);

  state_e          st_q, st_d;
  logic [LOGN-1:0] wcnt_q, wcnt_d;
  logic [LOGN-1:0] rcnt_q, rcnt_d;
  logic            wbank_q, wbank_d;
  logic            osel_q, osel_d;
  logic            ovld_q, ovld_d;
  logic            ofirst_q, ofirst_d;
  logic            frm_err_q, frm_err_d;

  logic            start_eff;
  logic            reading;
  logic            writing;
  logic            wcnt_last;
  logic            rcnt_last;
  logic [LOGN-1:0] waddr;
  logic [LOGN-1:0] raddr;

  assign start_eff = ED & START;
  assign reading   = (st_q == ST_DRAIN) || (st_q == ST_STREAM);
  assign writing   = (st_q == ST_FILL) || (st_q == ST_STREAM) || start_eff;
  assign wcnt_last = (wcnt_q == '1);
  assign rcnt_last = (rcnt_q == '1);
  assign waddr     = start_eff ? '0 : wcnt_q;

`ifdef FFT_BITREV_EN
  ram64_reorder_ctrl_addr_bitrev u_bitrev (
    .addr_in  (rcnt_q),
    .addr_out (raddr)
  );
`else
  assign raddr = rcnt_q;
`endif

  // Write bank is wbank, read bank is always the other one, so the two never collide.
  always_comb begin
    ADDR0 = '0;
    WE0   = 1'b0;
    ADDR1 = '0;
    WE1   = 1'b0;
    if (writing) begin
      if (wbank_q) begin
        ADDR1 = waddr;
        WE1   = ED;
      end else begin
        ADDR0 = waddr;
        WE0   = ED;
      end
    end
    if (reading) begin
      if (wbank_q) ADDR0 = raddr;
      else         ADDR1 = raddr;
    end
  end

  always_comb begin
    st_d      = st_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    wbank_d   = wbank_q;
    osel_d    = osel_q;
    ovld_d    = ovld_q;
    ofirst_d  = ofirst_q;
    frm_err_d = frm_err_q;
    if (ED) begin
      ovld_d    = reading;
      osel_d    = ~wbank_q;
      ofirst_d  = reading && (rcnt_q == '0);
      frm_err_d = 1'b0;
      if (reading) rcnt_d = rcnt_q + CNT_ONE;
      unique case (st_q)
        ST_IDLE: begin
          if (start_eff) begin
            wcnt_d = CNT_ONE;
            st_d   = ST_FILL;
          end
        end
        ST_FILL: begin
          if (start_eff) begin
            wcnt_d    = CNT_ONE;
            frm_err_d = 1'b1;
          end else if (wcnt_last) begin
            wbank_d = ~wbank_q;
            rcnt_d  = '0;
            wcnt_d  = '0;
            st_d    = ST_DRAIN;
          end else begin
            wcnt_d = wcnt_q + CNT_ONE;
          end
        end
        ST_DRAIN: begin
          if (start_eff) begin
            wcnt_d = CNT_ONE;
            st_d   = rcnt_last ? ST_FILL : ST_STREAM;
          end else if (rcnt_last) begin
            st_d = ST_IDLE;
          end
        end
        ST_STREAM: begin
          // A restart keeps reading; a completed write swaps banks even if the read also ends.
          if (start_eff) begin
            wcnt_d    = CNT_ONE;
            frm_err_d = 1'b1;
            if (rcnt_last) st_d = ST_FILL;
          end else if (wcnt_last) begin
            wbank_d = ~wbank_q;
            rcnt_d  = '0;
            wcnt_d  = '0;
            st_d    = ST_DRAIN;
          end else begin
            wcnt_d = wcnt_q + CNT_ONE;
            if (rcnt_last) st_d = ST_FILL;
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      st_q      <= ST_IDLE;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      wbank_q   <= 1'b0;
      osel_q    <= 1'b0;
      ovld_q    <= 1'b0;
      ofirst_q  <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      wbank_q   <= wbank_d;
      osel_q    <= osel_d;
      ovld_q    <= ovld_d;
      ofirst_q  <= ofirst_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign OSEL    = osel_q;
  assign OVLD    = ovld_q;
  assign OFIRST  = ofirst_q;
  assign FRM_ERR = frm_err_q;

endmodule
